// File: rtl/lsq_pkg.sv
// Load/store queue shared definitions: funct3 encodings, the NULL tag,
// FSM state encoding and a width-compare helper.
package lsq_pkg;

  localparam logic [2:0] OP_B  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_W  = 3'd2;
  localparam logic [2:0] OP_BU = 3'd4;
  localparam logic [2:0] OP_HU = 3'd5;

  localparam int NULL_TAG = 0;

  typedef logic [1:0] lsq_state_t;

  localparam lsq_state_t S_IDLE  = 2'd0;
  localparam lsq_state_t S_LOAD  = 2'd1;
  localparam lsq_state_t S_STORE = 2'd2;
  localparam lsq_state_t S_DRAIN = 2'd3;

  // Byte/half/word size lives in the low two funct3 bits.
  function automatic logic same_width(input logic [2:0] a,
                                      input logic [2:0] b);
    return a[1:0] == b[1:0];
  endfunction

endpackage

// File: rtl/lsq_load_extend.sv
// Combinational load-data extension by funct3.
// Ports: op (funct3), raw (memory word), data (extended result).
module lsq_load_extend
  import lsq_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (op)
      OP_B:    data = {{24{raw[7]}}, raw[7:0]};
      OP_H:    data = {{16{raw[15]}}, raw[15:0]};
      OP_BU:   data = {24'd0, raw[7:0]};
      OP_HU:   data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue with operand snooping, commit tracking,
// rollback, and a single outstanding memory access.
// Ports: clk/rst (sync, active-high), alloc_* enqueue, cdb_* snoop,
// commit_*, rollback, mem_* request/response, ld_* load broadcast, full.
// Option: LSQ_STORE_FORWARD_EN enables last-store to load forwarding.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  full,
  input  logic                  alloc_valid,
  input  logic                  alloc_store,
  input  logic [2:0]            alloc_op,
  input  logic [TAG_W-1:0]      alloc_tag,
  input  logic [31:0]           alloc_base_v,
  input  logic [TAG_W-1:0]      alloc_base_q,
  input  logic [31:0]           alloc_data_v,
  input  logic [TAG_W-1:0]      alloc_data_q,
  input  logic [31:0]           alloc_imm,
  input  logic [CDB_N-1:0]      cdb_valid,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*32-1:0]   cdb_data,
  input  logic                  commit_valid,
  input  logic [TAG_W-1:0]      commit_tag,
  input  logic                  rollback,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [2:0]            mem_op,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  ld_valid,
  output logic [TAG_W-1:0]      ld_tag,
  output logic [31:0]           ld_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TAG_W-1:0] NQ = TAG_W'(NULL_TAG);

  logic             e_store [DEPTH];
  logic             e_cmt   [DEPTH];
  logic [2:0]       e_op    [DEPTH];
  logic [TAG_W-1:0] e_tag   [DEPTH];
  logic [TAG_W-1:0] e_bq    [DEPTH];
  logic [TAG_W-1:0] e_dq    [DEPTH];
  logic [31:0]      e_bv    [DEPTH];
  logic [31:0]      e_dv    [DEPTH];
  logic [31:0]      e_imm   [DEPTH];

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, cmt_cnt, resident;
  lsq_state_t       state;
  logic [TAG_W-1:0] cur_tag;
  logic [2:0]       cur_op;

  logic [DEPTH-1:0] in_use, cmt_hit;
  logic             any_cmt, head_ready, issue;
  logic             alloc_ok, store_done, fwd_hit;
  logic [31:0]      head_addr, ext_data, ext_raw;
  logic [2:0]       ext_op;

  // Resolve a pending operand against every broadcast source.
  function automatic logic [TAG_W+31:0] snoop(
    input logic [TAG_W-1:0] q,
    input logic [31:0]      v
  );
    logic [TAG_W-1:0] nq;
    logic [31:0]      nv;
    nq = q;
    nv = v;
    if (q != NQ) begin
      for (int c = 0; c < CDB_N; c++) begin
        if (cdb_valid[c] &&
            cdb_tag[c*TAG_W +: TAG_W] == q) begin
          nq = NQ;
          nv = cdb_data[c*32 +: 32];
        end
      end
      if (ld_valid && ld_tag == q) begin
        nq = NQ;
        nv = ld_data;
      end
    end
    return {nq, nv};
  endfunction

  always_comb begin
    in_use  = '0;
    cmt_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      in_use[i] = {1'b0, PW'(PW'(i) - head)} < count;
      cmt_hit[i] = commit_valid && in_use[i] &&
                   e_store[i] && !e_cmt[i] &&
                   e_tag[i] == commit_tag;
    end
  end

  assign any_cmt    = |cmt_hit;
  assign full       = count == CW'(DEPTH);
  assign head_addr  = e_bv[head] + e_imm[head];
  assign head_ready = count != '0 && e_bq[head] == NQ &&
                      (!e_store[head] ||
                       (e_cmt[head] && e_dq[head] == NQ));
  assign issue      = state == S_IDLE && head_ready && !rollback;
  assign alloc_ok   = alloc_valid && !full && !rollback;
  assign store_done = state == S_STORE && mem_ready;
  // An in-flight store already left the queue but is still counted.
  assign resident   = cmt_cnt - CW'(state == S_STORE);

`ifdef LSQ_STORE_FORWARD_EN
  logic        fwd_v;
  logic [31:0] fwd_addr, fwd_data;
  logic [2:0]  fwd_op;

  assign fwd_hit = issue && !e_store[head] && fwd_v &&
                   fwd_addr == head_addr &&
                   same_width(fwd_op, e_op[head]);
  assign ext_op  = state == S_LOAD ? cur_op : e_op[head];
  assign ext_raw = state == S_LOAD ? mem_rdata : fwd_data;
`else
  assign fwd_hit = 1'b0;
  assign ext_op  = cur_op;
  assign ext_raw = mem_rdata;
`endif

  lsq_load_extend u_ext (
    .op   (ext_op),
    .raw  (ext_raw),
    .data (ext_data)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      {e_bq[i], e_bv[i]} <= snoop(e_bq[i], e_bv[i]);
      {e_dq[i], e_dv[i]} <= snoop(e_dq[i], e_dv[i]);
      if (cmt_hit[i] && !rollback) e_cmt[i] <= 1'b1;
    end
    if (alloc_ok) begin
      e_store[tail] <= alloc_store;
      e_op[tail]    <= alloc_op;
      e_tag[tail]   <= alloc_tag;
      e_imm[tail]   <= alloc_imm;
      e_cmt[tail]   <= 1'b0;
      {e_bq[tail], e_bv[tail]} <= snoop(alloc_base_q, alloc_base_v);
      {e_dq[tail], e_dv[tail]} <= snoop(alloc_data_q, alloc_data_v);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cmt_cnt   <= '0;
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_op    <= '0;
      mem_wdata <= '0;
      ld_valid  <= 1'b0;
      ld_tag    <= '0;
      ld_data   <= '0;
      cur_tag   <= '0;
      cur_op    <= '0;
`ifdef LSQ_STORE_FORWARD_EN
      fwd_v     <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
      fwd_op    <= '0;
`endif
    end else begin
      mem_req  <= 1'b0;
      ld_valid <= 1'b0;
      // Committed stores form the oldest prefix, so they survive.
      if (rollback) begin
        count <= resident;
        tail  <= head + PW'(resident);
      end else begin
        count <= count + CW'(alloc_ok) - CW'(issue);
        if (alloc_ok) tail <= tail + PW'(1);
      end
      if (issue) head <= head + PW'(1);
      cmt_cnt <= cmt_cnt + CW'(any_cmt && !rollback)
                         - CW'(store_done);
      case (state)
        S_IDLE: begin
          if (issue) begin
            if (fwd_hit) begin
              ld_valid <= 1'b1;
              ld_tag   <= e_tag[head];
              ld_data  <= ext_data;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= e_store[head];
              mem_addr  <= head_addr;
              mem_op    <= e_op[head];
              mem_wdata <= e_dv[head];
              cur_tag   <= e_tag[head];
              cur_op    <= e_op[head];
              state     <= e_store[head] ? S_STORE : S_LOAD;
            end
`ifdef LSQ_STORE_FORWARD_EN
            if (e_store[head]) begin
              fwd_v    <= 1'b1;
              fwd_addr <= head_addr;
              fwd_data <= e_dv[head];
              fwd_op   <= e_op[head];
            end
`endif
          end
        end
        S_LOAD: begin
          if (mem_ready) begin
            state <= S_IDLE;
            if (!rollback) begin
              ld_valid <= 1'b1;
              ld_tag   <= cur_tag;
              ld_data  <= ext_data;
            end
          end else if (rollback) begin
            state <= S_DRAIN;
          end
        end
        S_STORE: if (mem_ready) state <= S_IDLE;
        S_DRAIN: if (mem_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: directed stimulus pushes
// expected memory requests and load results; a monitor checks them.
module tb_load_store_queue;

  logic        clk, rst;
  logic        full;
  logic        alloc_valid, alloc_store;
  logic [2:0]  alloc_op;
  logic [3:0]  alloc_tag, alloc_base_q, alloc_data_q;
  logic [31:0] alloc_base_v, alloc_data_v, alloc_imm;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic        rollback;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_op;
  logic        ld_valid;
  logic [3:0]  ld_tag;
  logic [31:0] ld_data;

  load_store_queue dut (
    .clk(clk), .rst(rst), .full(full),
    .alloc_valid(alloc_valid), .alloc_store(alloc_store),
    .alloc_op(alloc_op), .alloc_tag(alloc_tag),
    .alloc_base_v(alloc_base_v), .alloc_base_q(alloc_base_q),
    .alloc_data_v(alloc_data_v), .alloc_data_q(alloc_data_q),
    .alloc_imm(alloc_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .rollback(rollback),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_op(mem_op), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  op;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } lres_t;

  mreq_t       mq[$];
  lres_t       lq[$];
  logic [31:0] rsp_q[$];
  int          mem_lat = 2;
  int          total = 0;
  int          passed = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory model: answers each request after mem_lat cycles.
  initial begin
    int  lat;
    logic w;
    mem_ready = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        lat = mem_lat;
        w   = mem_we;
        repeat (lat) @(posedge clk);
        #1;
        mem_ready = 1;
        if (!w && rsp_q.size() > 0) mem_rdata = rsp_q.pop_front();
        else mem_rdata = 0;
        @(posedge clk);
        #1;
        mem_ready = 0;
      end
    end
  end

  // Monitor: compare every DUT output event with the scoreboard.
  always @(negedge clk) begin
    mreq_t m;
    lres_t l;
    if (!rst) begin
      if (mem_req) begin
        total++;
        if (mq.size() == 0) begin
          $display("FAIL mem_req unexpected: we=%b addr=%h op=%0d",
                   mem_we, mem_addr, mem_op);
        end else begin
          m = mq.pop_front();
          if (mem_we === m.we && mem_addr === m.addr &&
              mem_op === m.op &&
              (!m.we || mem_wdata === m.wdata))
            passed++;
          else
            $display("FAIL mem_req: got we=%b addr=%h op=%0d wd=%h, want we=%b addr=%h op=%0d wd=%h",
                     mem_we, mem_addr, mem_op, mem_wdata,
                     m.we, m.addr, m.op, m.wdata);
        end
      end
      if (ld_valid) begin
        total++;
        if (lq.size() == 0) begin
          $display("FAIL ld_valid unexpected: tag=%0d data=%h",
                   ld_tag, ld_data);
        end else begin
          l = lq.pop_front();
          if (ld_tag === l.tag && ld_data === l.data)
            passed++;
          else
            $display("FAIL ld_result: got tag=%0d data=%h, want tag=%0d data=%h",
                     ld_tag, ld_data, l.tag, l.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic st, input logic [2:0] op,
                       input logic [3:0] tag, input logic [31:0] bv,
                       input logic [3:0] bq, input logic [31:0] dv,
                       input logic [3:0] dq, input logic [31:0] imm);
    alloc_valid  = 1;
    alloc_store  = st;
    alloc_op     = op;
    alloc_tag    = tag;
    alloc_base_v = bv;
    alloc_base_q = bq;
    alloc_data_v = dv;
    alloc_data_q = dq;
    alloc_imm    = imm;
    tick();
    alloc_valid  = 0;
  endtask

  task automatic bcast(input int ch, input logic [3:0] tag,
                       input logic [31:0] data);
    cdb_valid[ch]          = 1;
    cdb_tag[ch*4 +: 4]     = tag;
    cdb_data[ch*32 +: 32]  = data;
    tick();
    cdb_valid = 0;
  endtask

  task automatic commit(input logic [3:0] tag);
    commit_valid = 1;
    commit_tag   = tag;
    tick();
    commit_valid = 0;
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr,
                         input logic [2:0] op, input logic [31:0] wd);
    mq.push_back('{we, addr, op, wd});
  endtask

  task automatic exp_ld(input logic [3:0] tag, input logic [31:0] d);
    lq.push_back('{tag, d});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mq.size() != 0 || lq.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    total++;
    if (n < 500) passed++;
    else $display("FAIL %s drain timeout: mq=%0d lq=%0d pending",
                  name, mq.size(), lq.size());
    repeat (8) tick();
  endtask

  initial begin
    int n;
    rst = 1;
    alloc_valid = 0; alloc_store = 0; alloc_op = 0; alloc_tag = 0;
    alloc_base_v = 0; alloc_base_q = 0; alloc_data_v = 0;
    alloc_data_q = 0; alloc_imm = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    commit_valid = 0; commit_tag = 0; rollback = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset full", 32'(full), 0);
    check("reset mem_req", 32'(mem_req), 0);
    check("reset ld_valid", 32'(ld_valid), 0);
    check("reset ld_data", ld_data, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset count", 32'(dut.count), 0);
    rst = 0;
    tick();

    // LW tag 3 from 0x100+4
    exp_mem(0, 32'h104, 3'd2, 0);
    rsp_q.push_back(32'hDEADBEEF);
    exp_ld(3, 32'hDEADBEEF);
    alloc(0, 3'd2, 3, 32'h100, 0, 0, 0, 4);
    drain("lw");

    // SB waits for data tag 2 and commit 5
    alloc(1, 3'd0, 5, 32'h200, 0, 0, 2, 0);
    repeat (3) tick();
    exp_mem(1, 32'h200, 3'd0, 32'h1FF);
    bcast(1, 2, 32'h1FF);
    commit(5);
    commit(5);
    drain("sb");

    // Extension cases
    exp_mem(0, 32'h301, 3'd0, 0);
    rsp_q.push_back(32'h80);
    exp_ld(6, 32'hFFFFFF80);
    alloc(0, 3'd0, 6, 32'h300, 0, 0, 0, 1);
    drain("lb");
    exp_mem(0, 32'h302, 3'd4, 0);
    rsp_q.push_back(32'h80);
    exp_ld(7, 32'h00000080);
    alloc(0, 3'd4, 7, 32'h300, 0, 0, 0, 2);
    drain("lbu");
    exp_mem(0, 32'h304, 3'd1, 0);
    rsp_q.push_back(32'h00008001);
    exp_ld(8, 32'hFFFF8001);
    alloc(0, 3'd1, 8, 32'h300, 0, 0, 0, 4);
    drain("lh");
    exp_mem(0, 32'h306, 3'd5, 0);
    rsp_q.push_back(32'h00008001);
    exp_ld(9, 32'h00008001);
    alloc(0, 3'd5, 9, 32'h300, 0, 0, 0, 6);
    drain("lhu");

    // Operand captured from CDB in the allocation cycle
    exp_mem(0, 32'h510, 3'd2, 0);
    rsp_q.push_back(32'hCAFEF00D);
    exp_ld(9, 32'hCAFEF00D);
    cdb_valid[0]   = 1;
    cdb_tag[3:0]   = 11;
    cdb_data[31:0] = 32'h500;
    alloc(0, 3'd2, 9, 32'h0, 11, 0, 0, 32'h10);
    cdb_valid = 0;
    drain("alloc_snoop");

    // Fill all entries (pointers wrap), ninth ignored
    for (int i = 0; i < 8; i++)
      alloc(0, 3'd2, 4'(i + 1), 0, 12, 0, 0, 32'(4 * i));
    check("full after 8", 32'(full), 1);
    alloc(0, 3'd2, 10, 0, 12, 0, 0, 32'h900);
    check("full after 9th", 32'(full), 1);
    check("count after 9th", 32'(dut.count), 8);
    for (int i = 0; i < 8; i++) begin
      exp_mem(0, 32'h2000 + 32'(4 * i), 3'd2, 0);
      rsp_q.push_back(32'hA0 + 32'(i));
      exp_ld(4'(i + 1), 32'hA0 + 32'(i));
    end
    bcast(0, 12, 32'h2000);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("full after pop", 32'(full), 0);
    tick();
    drain("fill");

    // Rollback with a load in flight behind two committed stores
    mem_lat = 12;
    exp_mem(0, 32'h3000, 3'd2, 0);
    rsp_q.push_back(32'h55);
    alloc(0, 3'd2, 1, 32'h3000, 0, 0, 0, 0);
    alloc(1, 3'd2, 2, 32'h3100, 0, 32'h11, 0, 0);
    alloc(1, 3'd2, 3, 32'h3104, 0, 32'h22, 0, 0);
    alloc(0, 3'd2, 4, 32'h3200, 0, 0, 0, 0);
    alloc(0, 3'd2, 5, 32'h3204, 0, 0, 0, 0);
    commit(2);
    commit(3);
    mem_lat = 2;
    exp_mem(1, 32'h3100, 3'd2, 32'h11);
    exp_mem(1, 32'h3104, 3'd2, 32'h22);
    rollback = 1;
    tick();
    rollback = 0;
    check("count after rollback", 32'(dut.count), 2);
    drain("rollback");
    check("count after stores", 32'(dut.count), 0);

    // Store then load to the same word
    exp_mem(1, 32'h40, 3'd2, 32'h12345678);
`ifndef LSQ_STORE_FORWARD_EN
    exp_mem(0, 32'h40, 3'd2, 0);
    rsp_q.push_back(32'h12345678);
`endif
    exp_ld(7, 32'h12345678);
    alloc(1, 3'd2, 6, 32'h40, 0, 32'h12345678, 0, 0);
    alloc(0, 3'd2, 7, 32'h40, 0, 0, 0, 0);
    commit(6);
    drain("forward");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 DEPTH, 8, entry count; power of two, at least 2.
REQ-002 TAG_W, 4, ROB tag width; tag 0 = NULL (no dependency).
REQ-003 CDB_N, 2, number of result-broadcast channels snooped.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 full  out  1  high when count == DEPTH.
REQ-007 alloc_valid  in  1  enqueue request.
REQ-008 alloc_store  in  1  1 = store, 0 = load.
REQ-009 alloc_op  in  3  funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-010 alloc_tag  in  TAG_W  ROB tag of the entry.
REQ-011 alloc_base_v / alloc_base_q  in  32 / TAG_W  base value and producer tag.
REQ-012 alloc_data_v / alloc_data_q  in  32 / TAG_W  store data value and producer tag.
REQ-013 alloc_imm  in  32  address offset.
REQ-014 cdb_valid / cdb_tag / cdb_data  in  CDB_N / CDB_N*TAG_W / CDB_N*32  packed broadcast channels.
REQ-015 commit_valid / commit_tag  in  1 / TAG_W  ROB commits the store carrying this tag.
REQ-016 rollback  in  1  misprediction flush.
REQ-017 mem_req / mem_we / mem_addr / mem_op / mem_wdata  out  1/1/32/3/32  one-cycle memory request pulse with fields.
REQ-018 mem_ready / mem_rdata  in  1 / 32  access complete, load data.
REQ-019 ld_valid / ld_tag / ld_data  out  1 / TAG_W / 32  load-result broadcast pulse.

Function
REQ-020 Circular queue with head, tail and an explicit count, so that all DEPTH entries are usable; pointers wrap modulo DEPTH.
REQ-021 alloc_valid with full=0 writes the entry at tail; alloc_valid while full is ignored and nothing changes.
REQ-022 Any valid CDB channel, or ld_valid, whose tag equals an entry's non-NULL q field sets q=NULL and captures the data; this also applies to the operands being allocated in the same cycle.
REQ-023 A commit matching a store entry sets its committed flag and increments committed_cnt; a commit that matches no entry is ignored.
REQ-024 FSM states: IDLE, LOAD, STORE, DRAIN.
REQ-025 IDLE and head ready: pulse mem_req with addr = base+imm (mod 2^32), pop head, go to LOAD or STORE. A load is ready when base_q is NULL; a store is ready when committed and both q fields are NULL.
REQ-026 STORE and mem_ready: go to IDLE and decrement committed_cnt. LOAD and mem_ready: go to IDLE and pulse ld_valid in the next cycle with the data sign- or zero-extended per op.
REQ-027 The next mem_req comes no earlier than the cycle after mem_ready.
REQ-028 rollback has priority over same-cycle alloc and commit:
- count <= committed_cnt and tail <= head + committed_cnt;
- a LOAD in flight goes to DRAIN, which waits for mem_ready, discards the data, emits no ld_valid, then returns to IDLE;
- a STORE in flight completes normally.
REQ-029 An issue and a commit in the same cycle both adjust committed_cnt correctly (net effect).

Reset
REQ-030 rst clears head, tail, count and committed_cnt, sets the FSM to IDLE, and drives mem_req, ld_valid and full to 0. Data outputs go to 0. rst mid-access abandons the access.

Configuration
REQ-031 LSQ_STORE_FORWARD_EN defined:
- a last-store register (address, op, data) is written on every store issue;
- a head load with identical address and width, issued while no store is in flight, skips memory and pulses ld_valid one cycle later with the extended data;
- the register is cleared by rst.
REQ-032 LSQ_STORE_FORWARD_EN undefined: every load accesses memory.

Structure
REQ-033 Shared package lsq_pkg holds the op encodings, NULL_TAG, and the FSM state typedef.
REQ-034 Sub-module lsq_load_extend: combinational sign/zero extension selected by op.

Verification
REQ-035 Allocate LW with tag 3, base_v=0x100, imm=4; mem_ready after 2 cycles with rdata 0xDEADBEEF -> mem_addr=0x104, then ld_valid with tag 3 and data 0xDEADBEEF.
REQ-036 Allocate SB with tag 5 and data_q=2; broadcast tag 2 with 0x1FF; commit 5 -> exactly one mem_req, we=1, wdata 0x1FF, op 0.
REQ-037 Fill DEPTH=8 entries -> full=1; 9th alloc ignored; pop one -> full=0; wrap-around order is preserved.
REQ-038 Two committed stores plus three loads, with a load in flight, then rollback -> count=2, no ld_valid, both stores later issue.
REQ-039 LB with rdata 0x80 -> 0xFFFFFF80; LBU -> 0x00000080.
REQ-040 With LSQ_STORE_FORWARD_EN: SW 0x12345678 to 0x40 then LW from 0x40 -> no load mem_req, ld_data 0x12345678.
